ctle_adapt_ctrl: RTL

Digital adaptation controller for the receive-side CTLE. It sweeps the CTLE peaking code over a programmable range. For each code it waits for the analog filter to settle, then counts slicer errors over a fixed number of valid samples. It keeps the code with the fewest errors and applies it. It sits between the slicer/error-detector output and the CTLE configuration input (the zero-frequency/peaking selection) and is the only block that drives that code.

---
 rtl/ctle_adapt_pkg.sv | 18 +
 rtl/sat_cnt.sv | 28 ++
 rtl/ctle_adapt_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ctle_adapt_pkg.sv
// Shared types and helpers for the CTLE peaking-code adaptation controller.
package ctle_adapt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_APPLY,
    ST_DONE
  } state_e;

  // Number of codes visited by one sweep.
  function automatic int sweep_len(input int code_min, input int code_max);
    return code_max - code_min + 1;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: synchronous clear, enable, 1-bit increment.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en && inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ctle_adapt_ctrl.sv
// Sweeps the CTLE peaking code, counts slicer errors per code after settling,
// and applies the code with the fewest errors (ties keep the lower code).
module ctle_adapt_ctrl
  import ctle_adapt_pkg::*;
#(
  parameter int CODE_W     = 4,
  parameter int CODE_MIN   = 0,
  parameter int CODE_MAX   = 15,
  parameter int CODE_DEF   = 8,
  parameter int SETTLE_CYC = 64,
  parameter int DWELL_CYC  = 1024,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              err_vld,
  input  logic              err,
  output logic [CODE_W-1:0] code_out,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  best_err
);

  localparam int SW = $clog2(SETTLE_CYC) + 1;
  localparam int DW = $clog2(DWELL_CYC) + 1;

  localparam logic [CODE_W-1:0] CODE_MIN_L  = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] CODE_DEF_L  = CODE_W'(CODE_DEF);
  localparam logic [CODE_W-1:0] CODE_LAST_L =
    CODE_W'(CODE_MIN + sweep_len(CODE_MIN, CODE_MAX) - 1);
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [DW-1:0]     DWELL_LAST  = DW'(DWELL_CYC - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] r_best_code;
  logic [ERR_W-1:0]  r_best_err;
  logic [SW-1:0]     r_settle_cnt;
  logic [DW-1:0]     r_samp_cnt;
  logic [ERR_W-1:0]  w_err_cnt;
  logic              w_settle_last;
  logic              w_samp_last;
  logic              w_last_code;
  logic              w_err_clr;
  logic              w_err_en;

  assign w_settle_last = (r_settle_cnt == SETTLE_LAST);
  assign w_samp_last   = (r_samp_cnt == DWELL_LAST);
  assign w_last_code   = (r_code == CODE_LAST_L);
  assign w_err_clr     = (r_state == ST_SETTLE) && w_settle_last;
  assign w_err_en      = (r_state == ST_MEASURE) && err_vld;

  sat_cnt #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk (clk),
    .rstn(rstn),
    .clr (w_err_clr),
    .en  (w_err_en),
    .inc (err),
    .q   (w_err_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_SETTLE;
      ST_SETTLE:        if (w_settle_last) w_state_nxt = ST_MEASURE;
      ST_MEASURE:       if (err_vld && w_samp_last) w_state_nxt = ST_EVAL;
      ST_EVAL:          w_state_nxt = w_last_code ? ST_APPLY : ST_SETTLE;
      ST_APPLY:         w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_code       <= CODE_DEF_L;
      r_best_code  <= CODE_MIN_L;
      r_best_err   <= '1;
      r_settle_cnt <= '0;
      r_samp_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_code       <= CODE_MIN_L;
            r_best_code  <= CODE_MIN_L;
            r_best_err   <= '1;
            r_settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (w_settle_last) begin
            r_samp_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
          end
        end
        ST_MEASURE: begin
          if (err_vld) r_samp_cnt <= r_samp_cnt + DW'(1);
        end
        ST_EVAL: begin
          // Strict compare: an equal count never displaces the lower code.
          if (w_err_cnt < r_best_err) begin
            r_best_err  <= w_err_cnt;
            r_best_code <= r_code;
          end
          if (!w_last_code) begin
            r_code       <= r_code + CODE_W'(1);
            r_settle_cnt <= '0;
          end
        end
        ST_APPLY: r_code <= r_best_code;
        default: ;
      endcase
    end
  end

  assign code_out = r_code;
  assign best_err = r_best_err;
  assign busy     = (r_state == ST_SETTLE) || (r_state == ST_MEASURE) ||
                    (r_state == ST_EVAL)   || (r_state == ST_APPLY);
  assign done     = (r_state == ST_DONE);

endmodule
